// File: rtl/vrased_reset_ctrl_pkg.sv
// Shared definitions for the VRASED reset controller: FSM encoding, violation
// bit positions, counter width and a saturating-increment helper.
package vrased_reset_ctrl_pkg;

    localparam int CNT_W  = 8;
    localparam int VIOL_W = 6;

    localparam int VIOL_X_STACK     = 0;
    localparam int VIOL_AC          = 1;
    localparam int VIOL_ATOMICITY   = 2;
    localparam int VIOL_DMA_AC      = 3;
    localparam int VIOL_DMA_DETECT  = 4;
    localparam int VIOL_DMA_X_STACK = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/vrased_down_counter.sv
// Loadable 8-bit down counter that stops at zero and flags when it is there.
module vrased_down_counter
    import vrased_reset_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_zero
);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/vrased_reset_ctrl.sv
// VRASED reset controller: holds puc_req after violations, then waits for the core
// to reach its reset handler. Optional cause/episode logging under VRASED_CAUSE_LOG_EN.
module vrased_reset_ctrl
    import vrased_reset_ctrl_pkg::*;
#(
    parameter int          HOLD_CYCLES     = 4,
    parameter int          RECOVER_TIMEOUT = 16,
    parameter logic [15:0] RESET_HANDLER   = 16'h0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [VIOL_W-1:0] viol,
    input  logic [15:0]       pc,
    input  logic              cause_clr,
    output logic              puc_req,
    output logic              busy,
    output logic [VIOL_W-1:0] cause,
    output logic [CNT_W-1:0]  viol_cnt
);

    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REC_LOAD  = CNT_W'(RECOVER_TIMEOUT - 1);

    state_t r_state;
    state_t w_next;
    logic   r_puc_req;
    logic   r_busy;
    logic   w_any_viol;
    logic   w_hold_load, w_hold_dec, w_hold_zero;
    logic   w_to_load, w_to_dec, w_to_zero;
    logic   w_new_episode;

    assign w_any_viol = |viol;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next        = r_state;
        w_hold_load   = 1'b0;
        w_hold_dec    = 1'b0;
        w_to_load     = 1'b0;
        w_to_dec      = 1'b0;
        w_new_episode = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_viol) begin
                    w_next        = ST_HOLD;
                    w_hold_load   = 1'b1;
                    w_new_episode = 1'b1;
                end
            end
            ST_HOLD: begin
                if (w_any_viol) begin
                    w_hold_load = 1'b1;
                end else if (w_hold_zero) begin
                    w_next    = ST_RECOVER;
                    w_to_load = 1'b1;
                end else begin
                    w_hold_dec = 1'b1;
                end
            end
            ST_RECOVER: begin
                // A fresh violation outranks both a pc match and the timeout.
                if (w_any_viol || ((pc != RESET_HANDLER) && w_to_zero)) begin
                    w_next        = ST_HOLD;
                    w_hold_load   = 1'b1;
                    w_new_episode = 1'b1;
                end else if (pc == RESET_HANDLER) begin
                    w_next = ST_IDLE;
                end else begin
                    w_to_dec = 1'b1;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_puc_req <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_puc_req <= (w_next == ST_HOLD);
            r_busy    <= (w_next != ST_IDLE);
        end
    end

    assign puc_req = r_puc_req;
    assign busy    = r_busy;

    vrased_down_counter u_hold_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_hold_load),
        .i_load_val (HOLD_LOAD),
        .i_dec      (w_hold_dec),
        .o_zero     (w_hold_zero)
    );

    vrased_down_counter u_timeout_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_to_load),
        .i_load_val (REC_LOAD),
        .i_dec      (w_to_dec),
        .o_zero     (w_to_zero)
    );

`ifdef VRASED_CAUSE_LOG_EN
    logic [VIOL_W-1:0] r_cause;
    logic [CNT_W-1:0]  r_viol_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cause    <= '0;
            r_viol_cnt <= '0;
        end else begin
            if ((r_state == ST_IDLE) && !w_any_viol && cause_clr) begin
                r_cause <= '0;
            end else begin
                r_cause <= r_cause | viol;
            end
            if (w_new_episode) begin
                r_viol_cnt <= sat_inc(r_viol_cnt);
            end
        end
    end

    assign cause    = r_cause;
    assign viol_cnt = r_viol_cnt;
`else
    logic w_unused_log;
    assign w_unused_log = cause_clr ^ w_new_episode;
    assign cause        = '0;
    assign viol_cnt     = '0;
`endif

endmodule

// File: doc/vrased_reset_ctrl.md
VRASED_RESET_CTRL -- requirements
Module: vrased_reset_ctrl

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: cycles puc_req is held after the last violation (range 1..255).
REQ-002 SHALL have parameter RECOVER_TIMEOUT, default 16: cycles allowed after release for pc to reach RESET_HANDLER (range 1..255).
REQ-003 SHALL have parameter RESET_HANDLER, default 16'h0000: core reset-vector fetch address.
REQ-004 SHALL have port clk  input  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1: synchronous, active-high block reset.
REQ-006 SHALL have port viol  input  6: per-monitor violation flags: [0] X_stack, [1] AC, [2] atomicity, [3] dma_AC, [4] dma_detect, [5] dma_X_stack.
REQ-007 SHALL have port pc  input  16: core program counter.
REQ-008 SHALL have port cause_clr  input  1: single-cycle request to clear the cause log.
REQ-009 SHALL have port puc_req  output  1: registered core reset request.
REQ-010 SHALL have port busy  output  1: high in any state other than IDLE.
REQ-011 SHALL have port cause  output  6: sticky OR of all viol bits seen since the last clear.
REQ-012 SHALL have port viol_cnt  output  8: saturating count of violation episodes.

Function
REQ-013 SHALL implement FSM states IDLE, HOLD and RECOVER; puc_req SHALL be high exactly in HOLD, registered, 1-cycle latency from viol.
REQ-014 In IDLE, viol != 0 SHALL move to HOLD, load hold counter with HOLD_CYCLES-1 and increment viol_cnt.
REQ-015 In HOLD, viol != 0 SHALL reload the hold counter to HOLD_CYCLES-1 and SHALL NOT increment viol_cnt.
REQ-016 In HOLD, with viol == 0 and hold counter 0, SHALL move to RECOVER and load the timeout counter with RECOVER_TIMEOUT-1.
REQ-017 In RECOVER, viol != 0 SHALL return to HOLD as a new episode, incrementing viol_cnt; this takes priority over pc match and timeout.
REQ-018 In RECOVER, pc == RESET_HANDLER SHALL move to IDLE.
REQ-019 In RECOVER, timeout counter 0 without a pc match SHALL return to HOLD as a new episode, incrementing viol_cnt.
REQ-020 Every cycle, cause SHALL become cause | viol.
REQ-021 cause_clr SHALL clear cause only in IDLE with viol == 0; in any other case it SHALL be ignored.
REQ-022 viol_cnt SHALL saturate at 8'hFF and never wrap.

Reset
REQ-023 reset high SHALL force IDLE, puc_req=0, busy=0, cause=0, viol_cnt=0 and both counters=0 on the next edge, including mid-HOLD or mid-RECOVER.
REQ-024 reset SHALL take priority over viol, pc and cause_clr in the same cycle.

Configuration
REQ-025 With VRASED_CAUSE_LOG_EN defined, cause and viol_cnt SHALL behave per REQ-020..022.
REQ-026 Without VRASED_CAUSE_LOG_EN, cause and viol_cnt SHALL be constant 0, their registers SHALL be absent, cause_clr SHALL be ignored, and FSM timing SHALL be identical.

Structure
REQ-027 A shared package SHALL hold the FSM state encoding, viol bit index constants (6 entries) and the counter width 8.
REQ-028 One sub-module, vrased_down_counter (load/decrement/zero flag, 8 bits), SHALL be instantiated twice: hold counter and timeout counter.

Verification
REQ-029 Single-cycle viol=6'b000010 in IDLE, HOLD_CYCLES=4: puc_req high exactly 4 cycles starting 1 cycle later; cause=6'b000010; viol_cnt=1.
REQ-030 viol=6'b000100 at t0, then viol=6'b100000 at HOLD cycle 2: HOLD extends to 4 cycles after the second pulse; cause=6'b100100; viol_cnt=1.
REQ-031 In RECOVER, pc=16'h0000 on cycle 3: IDLE next cycle, busy=0; cause_clr then gives cause=0 and leaves viol_cnt unchanged.
REQ-032 RECOVER with pc never 16'h0000, RECOVER_TIMEOUT=16: re-enters HOLD after 16 cycles; viol_cnt increments.
REQ-033 256 separate episodes: viol_cnt=8'hFF after the 255th and stays 8'hFF.
REQ-034 reset asserted mid-HOLD together with viol=6'b000001: next cycle IDLE, puc_req=0, cause=0, viol_cnt=0; with the macro undefined, cause and viol_cnt are 0 throughout REQ-029..033.
